// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//
// Multi-cycle sequencer for the signed MIPS-style mult instruction.
// The block watches the ALU control code and operands in the execute
// stage. When a valid multiply appears it stalls the pipeline and forms
// the signed 2*WIDTH-bit product. It uses one radix-2 shift-add step per
// cycle on the operand magnitudes, then fixes up the sign.
//
// Ports:
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset
//   valid_i     execute-stage instruction is valid
//   alu_ctrl_i  ALU control code; MULT_CODE launches a multiply
//   src1_i      multiplicand (rs), two's complement
//   src2_i      multiplier (rt), two's complement
//   flush_i     cancels an in-flight multiply, suppresses a new one
//   busy_o      multiply in progress (RUN or SIGN)
//   stall_o     hold the pipeline (combinational)
//   done_o      one-cycle pulse, hi_o/lo_o were just updated
//   hi_o        product bits [2*WIDTH-1:WIDTH]
//   lo_o        product bits [WIDTH-1:0]

module mult_seq_ctrl #(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] MULT_CODE = 4'b1111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH:0]       acc;
  logic                 neg;
  logic [CW-1:0]        count;

  logic                 start;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   result;

  assign start   = valid_i & (alu_ctrl_i == MULT_CODE) & (state == IDLE) & ~flush_i;
  assign stall_o = busy_o | start;

  // Unsigned negation maps the most negative value onto 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  assign mag1 = src1_i[WIDTH-1] ? -src1_i : src1_i;
  assign mag2 = src2_i[WIDTH-1] ? -src2_i : src2_i;

  // Partial sum carries one extra bit so the add never loses a carry.
  assign sum = mplier[0] ? (acc + {1'b0, mcand}) : acc;

  // After WIDTH shifts the low product bits have migrated into mplier.
  assign product = {acc[WIDTH-1:0], mplier};
  assign result  = neg ? -product : product;

  // Single sequencer: registered busy/done/hi/lo move with the state.
  // A flush wins over the step or the final write, so a cancelled
  // multiply never touches hi_o/lo_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      count  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag1;
            mplier <= mag2;
            neg    <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
            acc    <= '0;
            count  <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            acc    <= {1'b0, sum[WIDTH:1]};
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            count  <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state <= SIGN;
            end
          end
        end
        SIGN: begin
          busy_o <= 1'b0;
          state  <= IDLE;
          if (!flush_i) begin
            {hi_o, lo_o} <= result;
            done_o       <= 1'b1;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl
//
// Directed bench for mult_seq_ctrl with WIDTH=32. Inputs change on the
// falling edge and outputs are read on the falling edge, so nothing is
// sampled at the rising edge where the DUT updates.

module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int compared;
  int mismatched;

  mult_seq_ctrl #(
    .WIDTH     (32),
    .MULT_CODE (4'b1111)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .alu_ctrl_i (alu_ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .flush_i    (flush),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute watchdog so a stuck DUT cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Put a mult request on the inputs; caller is at a falling edge
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    valid    = 1'b1;
    alu_ctrl = 4'b1111;
    src1     = a;
    src2     = b;
  endtask

  // Step edges until done_o is seen (bounded). Edge 1 is the start edge;
  // the request is dropped and the operands scrambled right after it.
  task automatic wait_done(output int edges, output int busy_cycles, output bit seen);
    edges       = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        valid = 1'b0;
        src1  = 32'hDEADBEEF;
        src2  = 32'h12345678;
      end
      if (busy_o) busy_cycles++;
      if (done_o) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    compared++;
    if (done_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    compared++;
    if (stall_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
    compared++;
    if ({hi_o, lo_o} !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_hilo: got %h expected 0", {hi_o, lo_o}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int edges, busy_cycles;
    bit seen;
    launch(32'd3, 32'd5);
    #1;
    compared++;
    if (stall_o !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_stall_now: got %b expected 1", stall_o); end
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_busy_pre: got %b expected 0", busy_o); end
    wait_done(edges, busy_cycles, seen);
    compared++;
    if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_done_seen: got %b expected 1", seen); end
    compared++;
    if (edges !== 34) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 34", edges); end
    compared++;
    if (busy_cycles !== 33) begin mismatched++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 33", busy_cycles); end
    compared++;
    if (hi_o !== 32'd0) begin mismatched++; $display("[TB] FAIL basic_hi: got %h expected 0", hi_o); end
    compared++;
    if (lo_o !== 32'd15) begin mismatched++; $display("[TB] FAIL basic_lo: got %h expected f", lo_o); end
    @(negedge clk);
    compared++;
    if (done_o !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done_o); end
    compared++;
    if (lo_o !== 32'd15) begin mismatched++; $display("[TB] FAIL basic_lo_hold: got %h expected f", lo_o); end
  endtask

  task automatic test_signed();
    int edges, busy_cycles;
    bit seen;
    // -7 * 6 = -42
    launch(32'hFFFFFFF9, 32'd6);
    wait_done(edges, busy_cycles, seen);
    compared++;
    if (seen !== 1'b1 || {hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFD6) begin
      mismatched++; $display("[TB] FAIL signed_neg7x6: got %h expected ffffffffffffffd6", {hi_o, lo_o});
    end
    // (-2^31) * (-2^31) = 2^62
    @(negedge clk);
    launch(32'h80000000, 32'h80000000);
    wait_done(edges, busy_cycles, seen);
    compared++;
    if (seen !== 1'b1 || {hi_o, lo_o} !== 64'h40000000_00000000) begin
      mismatched++; $display("[TB] FAIL signed_minsq: got %h expected 4000000000000000", {hi_o, lo_o});
    end
    // (2^31-1) * (-1)
    @(negedge clk);
    launch(32'h7FFFFFFF, 32'hFFFFFFFF);
    wait_done(edges, busy_cycles, seen);
    compared++;
    if (seen !== 1'b1 || {hi_o, lo_o} !== 64'hFFFFFFFF_80000001) begin
      mismatched++; $display("[TB] FAIL signed_maxxm1: got %h expected ffffffff80000001", {hi_o, lo_o});
    end
  endtask

  task automatic test_ignore_busy();
    int edges;
    bit seen;
    @(negedge clk);
    launch(32'd12, 32'd10);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) valid = 1'b0;
      if (edges == 5) begin
        launch(32'd100, 32'd100);
        #1;
        compared++;
        if (stall_o !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_stall: got %b expected 1", stall_o); end
      end
      if (edges == 6) valid = 1'b0;
      if (done_o) seen = 1'b1;
    end
    compared++;
    if (edges !== 34) begin mismatched++; $display("[TB] FAIL busy_latency: got %0d expected 34", edges); end
    compared++;
    if ({hi_o, lo_o} !== 64'd120) begin mismatched++; $display("[TB] FAIL busy_result: got %h expected 78", {hi_o, lo_o}); end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cycles;
    bit seen;
    @(negedge clk);
    // 9 * -3 = -27
    launch(32'd9, 32'hFFFFFFFD);
    wait_done(edges, busy_cycles, seen);
    compared++;
    if (seen !== 1'b1 || {hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFE5) begin
      mismatched++; $display("[TB] FAIL b2b_first: got %h expected ffffffffffffffe5", {hi_o, lo_o});
    end
    // New request in the done_o cycle
    launch(32'd1000, 32'd2000);
    #1;
    compared++;
    if (stall_o !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_stall: got %b expected 1", stall_o); end
    wait_done(edges, busy_cycles, seen);
    compared++;
    if (seen !== 1'b1 || edges !== 34) begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d expected 34", edges); end
    compared++;
    if ({hi_o, lo_o} !== 64'd2000000) begin mismatched++; $display("[TB] FAIL b2b_second: got %h expected 1e8480", {hi_o, lo_o}); end
  endtask

  task automatic test_flush();
    int done_count;
    @(negedge clk);
    launch(32'd5, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) valid = 1'b0;
    end
    compared++;
    if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_busy_pre: got %b expected 1", busy_o); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_busy: got %b expected 0", busy_o); end
    compared++;
    if (stall_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_stall: got %b expected 0", stall_o); end
    compared++;
    if ({hi_o, lo_o} !== 64'd2000000) begin mismatched++; $display("[TB] FAIL flush_hilo: got %h expected 1e8480", {hi_o, lo_o}); end
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) done_count++;
      @(negedge clk);
    end
    compared++;
    if (done_count !== 0) begin mismatched++; $display("[TB] FAIL flush_no_done: got %0d expected 0", done_count); end
    // Flush in IDLE blocks the start
    launch(32'd2, 32'd2);
    flush = 1'b1;
    #1;
    compared++;
    if (stall_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_idle_stall: got %b expected 0", stall_o); end
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_idle_busy: got %b expected 0", busy_o); end
    valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_no_effect();
    int done_count;
    done_count = 0;
    valid    = 1'b1;
    alu_ctrl = 4'b0010;
    src1     = 32'd4;
    src2     = 32'd4;
    #1;
    compared++;
    if (stall_o !== 1'b0) begin mismatched++; $display("[TB] FAIL add_stall: got %b expected 0", stall_o); end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) done_count++;
    end
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL add_busy: got %b expected 0", busy_o); end
    valid    = 1'b0;
    alu_ctrl = 4'b1111;
    #1;
    compared++;
    if (stall_o !== 1'b0) begin mismatched++; $display("[TB] FAIL novalid_stall: got %b expected 0", stall_o); end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) done_count++;
    end
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL novalid_busy: got %b expected 0", busy_o); end
    compared++;
    if (done_count !== 0) begin mismatched++; $display("[TB] FAIL noeffect_done: got %0d expected 0", done_count); end
    compared++;
    if ({hi_o, lo_o} !== 64'd2000000) begin mismatched++; $display("[TB] FAIL noeffect_hilo: got %h expected 1e8480", {hi_o, lo_o}); end
  endtask

  task automatic test_reset_mid();
    int edges, busy_cycles;
    bit seen;
    launch(32'd5, 32'd7);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy_o); end
    compared++;
    if (done_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_done: got %b expected 0", done_o); end
    compared++;
    if ({hi_o, lo_o} !== 64'h0) begin mismatched++; $display("[TB] FAIL rstmid_hilo: got %h expected 0", {hi_o, lo_o}); end
    rst = 1'b0;
    // Recovery: 2 * -2 = -4
    launch(32'd2, 32'hFFFFFFFE);
    wait_done(edges, busy_cycles, seen);
    compared++;
    if (seen !== 1'b1 || {hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFC) begin
      mismatched++; $display("[TB] FAIL rstmid_recover: got %h expected fffffffffffffffc", {hi_o, lo_o});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    valid      = 1'b0;
    alu_ctrl   = 4'b0000;
    src1       = 32'd0;
    src2       = 32'd0;
    flush      = 1'b0;

    test_reset();
    test_basic();
    test_signed();
    test_ignore_busy();
    test_back_to_back();
    test_flush();
    test_no_effect();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
